// File: rtl/sig_product_resolver_pkg.sv
// Shared widths for the significand product resolver.
// IW/PW follow from SIG_WIDTH; SPLIT sets the carry-propagate adder split.
package sig_product_resolver_pkg;

    localparam int SIG_WIDTH = 52;
    localparam int PW        = 2 * (SIG_WIDTH + 1);
    localparam int IW        = PW + 5;
    localparam int SPLIT     = 56;
    localparam int HW        = PW - SPLIT;

endpackage

// File: rtl/sig_norm_round_prep.sv
// Normalizes a resolved significand product into mant/guard/sticky,
// the exponent-increment flag and the zero flag. Purely combinational.
module sig_norm_round_prep
    import sig_product_resolver_pkg::*;
(
    input  logic [PW-1:0]      i_prod,
    output logic [SIG_WIDTH:0] o_mant,
    output logic               o_guard,
    output logic               o_sticky,
    output logic               o_exp_inc,
    output logic               o_zero
);

    logic w_zero;

    assign w_zero = (i_prod == '0);

    always_comb begin
        o_mant    = '0;
        o_guard   = 1'b0;
        o_sticky  = 1'b0;
        o_exp_inc = 1'b0;
        o_zero    = w_zero;
        if (!w_zero) begin
            // Product in [2,4): keep the top bit as the integer bit.
            if (i_prod[PW-1]) begin
                o_exp_inc = 1'b1;
                o_mant    = i_prod[PW-1:PW-SIG_WIDTH-1];
                o_guard   = i_prod[PW-SIG_WIDTH-2];
                o_sticky  = |i_prod[PW-SIG_WIDTH-3:0];
            end else begin
                o_mant    = i_prod[PW-2:PW-SIG_WIDTH-2];
                o_guard   = i_prod[PW-SIG_WIDTH-3];
                o_sticky  = |i_prod[PW-SIG_WIDTH-4:0];
            end
        end
    end

endmodule

// File: rtl/sig_product_resolver.sv
// Resolves the multiplier sum/carry pair with a 2-stage split adder,
// normalizes the product and carries a sideband tag, valid/ready both sides.
module sig_product_resolver
    import sig_product_resolver_pkg::*;
#(
    parameter int TAG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW-1:0]        sum,
    input  logic [IW-1:0]        carry,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIG_WIDTH:0]   mant,
    output logic                 guard,
    output logic                 sticky,
    output logic                 exp_inc,
    output logic                 zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic                 r_v1;
    logic [SPLIT-1:0]     r_lo;
    logic                 r_c1;
    logic [HW-1:0]        r_sum_hi;
    logic [HW-1:0]        r_carry_hi;
    logic [TAG_WIDTH-1:0] r_tag1;

    logic                 r_v2;
    logic [SIG_WIDTH:0]   r_mant;
    logic                 r_guard;
    logic                 r_sticky;
    logic                 r_exp_inc;
    logic                 r_zero;
    logic [TAG_WIDTH-1:0] r_tag2;

    logic                 w_en1;
    logic                 w_en2;
    logic [SPLIT:0]       w_lo;
    logic [HW-1:0]        w_hi;
    logic [PW-1:0]        w_prod;
    logic [SIG_WIDTH:0]   w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_exp_inc;
    logic                 w_zero;
    logic                 w_unused_residue;

    assign w_en2    = !r_v2 | out_ready;
    assign w_en1    = !r_v1 | w_en2;
    assign in_ready = w_en1;

    // Bits above the product are sign/wrap residue and never matter.
    assign w_unused_residue = ^{sum[IW-1:PW], carry[IW-1:PW]};

    assign w_lo = {1'b0, sum[SPLIT-1:0]} + {1'b0, carry[SPLIT-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_lo       <= '0;
            r_c1       <= 1'b0;
            r_sum_hi   <= '0;
            r_carry_hi <= '0;
            r_tag1     <= '0;
        end else if (w_en1) begin
            r_v1       <= in_valid;
            r_lo       <= w_lo[SPLIT-1:0];
            r_c1       <= w_lo[SPLIT];
            r_sum_hi   <= sum[PW-1:SPLIT];
            r_carry_hi <= carry[PW-1:SPLIT];
            r_tag1     <= in_tag;
        end
    end

    assign w_hi   = r_sum_hi + r_carry_hi + HW'(r_c1);
    assign w_prod = {w_hi, r_lo};

    sig_norm_round_prep u_norm (
        .i_prod    (w_prod),
        .o_mant    (w_mant),
        .o_guard   (w_guard),
        .o_sticky  (w_sticky),
        .o_exp_inc (w_exp_inc),
        .o_zero    (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_mant    <= '0;
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
            r_exp_inc <= 1'b0;
            r_zero    <= 1'b0;
            r_tag2    <= '0;
        end else if (w_en2) begin
            r_v2      <= r_v1;
            r_mant    <= w_mant;
            r_guard   <= w_guard;
            r_sticky  <= w_sticky;
            r_exp_inc <= w_exp_inc;
            r_zero    <= w_zero;
            r_tag2    <= r_tag1;
        end
    end

    assign out_valid = r_v2;
    assign mant      = r_mant;
    assign guard     = r_guard;
    assign sticky    = r_sticky;
    assign exp_inc   = r_exp_inc;
    assign zero      = r_zero;
    assign out_tag   = r_tag2;

endmodule

// File: tb/tb_sig_product_resolver.sv
// Directed bench for sig_product_resolver: arithmetic corners,
// backpressure ordering and mid-flight reset.
module tb_sig_product_resolver;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [110:0] sum;
    logic [110:0] carry;
    logic [15:0]  in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [52:0]  mant;
    logic         guard;
    logic         sticky;
    logic         exp_inc;
    logic         zero;
    logic [15:0]  out_tag;

    int errors = 0;
    int checks = 0;

    sig_product_resolver #(.TAG_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant      (mant),
        .guard     (guard),
        .sticky    (sticky),
        .exp_inc   (exp_inc),
        .zero      (zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [110:0] p2(input int n);
        logic [110:0] one;
        one = 111'(1);
        return one << n;
    endfunction

    function automatic logic [52:0] m2(input int n);
        logic [52:0] one;
        one = 53'(1);
        return one << n;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic op(input string name, input logic [110:0] s,
                      input logic [110:0] c, input logic [15:0] t,
                      input logic [52:0] em, input logic eg,
                      input logic es, input logic ei, input logic ez);
        @(negedge clk);
        in_valid = 1'b1;
        sum      = s;
        carry    = c;
        in_tag   = t;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_lat1"}, 128'(out_valid), 128'(0));
        @(negedge clk);
        chk({name, "_valid"}, 128'(out_valid), 128'(1));
        chk({name, "_mant"}, 128'(mant), 128'(em));
        chk({name, "_guard"}, 128'(guard), 128'(eg));
        chk({name, "_sticky"}, 128'(sticky), 128'(es));
        chk({name, "_exp_inc"}, 128'(exp_inc), 128'(ei));
        chk({name, "_zero"}, 128'(zero), 128'(ez));
        chk({name, "_tag"}, 128'(out_tag), 128'(t));
    endtask

    initial begin
        logic [110:0] t53;
        int ns;
        int nr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum       = '0;
        carry     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_mant", 128'(mant), 128'(0));
        chk("rst_tag", 128'(out_tag), 128'(0));
        chk("rst_flags", 128'({guard, sticky, exp_inc, zero}), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b0;

        op("one", p2(104), '0, 16'h0001, m2(52), 0, 0, 0, 0);
        op("split", p2(104) | (p2(56) - 1), 111'(1), 16'h0002,
           m2(52) | m2(4), 0, 0, 0, 0);
        op("wrap", '1, 111'(1), 16'h0003, '0, 0, 0, 0, 1);
        t53 = p2(53) - 1;
        op("max", t53 * t53, '0, 16'h0004, m2(53) - 2, 0, 1, 1, 0);
        op("guard", p2(104) | p2(51), '0, 16'h0005, m2(52), 1, 0, 0, 0);
        op("inc_gs", p2(105) | p2(52) | p2(0), '0, 16'h0006,
           m2(52), 1, 1, 1, 0);
        op("residue", p2(110) | p2(104), '0, 16'h0007, m2(52), 0, 0, 0, 0);

        ns = 0;
        nr = 0;
        for (int cyc = 0; cyc < 40 && nr < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (ns < 5);
            if (ns < 5) begin
                sum    = p2(104) | (111'(ns) << 52);
                carry  = '0;
                in_tag = 16'hB0 + 16'(ns);
            end
            #1;
            if (cyc == 2 || cyc == 3) begin
                chk("bp_in_ready", 128'(in_ready), 128'(0));
                chk("bp_hold_valid", 128'(out_valid), 128'(1));
                chk("bp_hold_tag", 128'(out_tag), 128'(16'hB0));
                chk("bp_hold_mant", 128'(mant), 128'(m2(52)));
            end
            if (out_valid && out_ready) begin
                chk("bp_tag", 128'(out_tag), 128'(16'hB0 + 16'(nr)));
                chk("bp_mant", 128'(mant), 128'(m2(52) | 53'(nr)));
                nr++;
            end
            if (in_valid && in_ready) ns++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 128'(ns), 128'(5));
        chk("bp_recv", 128'(nr), 128'(5));
        @(negedge clk);
        chk("bp_no_dup", 128'(out_valid), 128'(0));

        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        sum      = p2(104);
        carry    = '0;
        in_tag   = 16'hC1;
        @(negedge clk);
        in_tag = 16'hC2;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstm_pre_valid", 128'(out_valid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_valid", 128'(out_valid), 128'(0));
        chk("rstm_mant", 128'(mant), 128'(0));
        chk("rstm_tag", 128'(out_tag), 128'(0));
        chk("rstm_flags", 128'({guard, sticky, exp_inc, zero}), 128'(0));
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstm_dropped", 128'(out_valid), 128'(0));
        end
        op("post_rst", p2(105), '0, 16'h00D1, m2(52), 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
